spi_frame_handler: RTL and testbench

- Sits directly downstream of the SPI slave stage: consumes its received frame bus and one-cycle `sync` pulse, and drives that stage's transmit frame bus.
- Supervises link health with a watchdog and holds the received payload outputs.
- Forces the payload outputs to a safe all-zero state on timeout.
- Requires a run of consecutive good frames before re-arming.

---
 rtl/spi_frame_pkg.sv | 29 ++
 rtl/spi_frame_watchdog.sv | 33 +++
 rtl/spi_frame_handler.sv | 144 ++++++++++++++
 tb/tb_spi_frame_handler.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/spi_frame_pkg.sv
// Shared types and helpers for the SPI frame handler.
// State encoding, TX header field widths and the TX header builder.
package spi_frame_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    TIMEOUT = 2'd2
  } state_t;

  localparam int ID_W     = 32;
  localparam int STATUS_W = 8;
  localparam int ERR_W    = 8;
  localparam int SEQ_W    = 8;
  localparam int HDR_W    = ID_W + STATUS_W + ERR_W;

  // Header = {msgid, status, err_cnt}; status = {state, timeout_flag, seq_err_sticky, good_cnt}
  function automatic logic [HDR_W-1:0] build_tx_header(
    input logic [ID_W-1:0]  msgid,
    input state_t           st,
    input logic             tflag,
    input logic             seq_err,
    input logic [3:0]       good,
    input logic [ERR_W-1:0] err
  );
    return {msgid, st, tflag, seq_err, good, err};
  endfunction

endpackage

// File: rtl/spi_frame_watchdog.sv
// Saturating link watchdog. Counts while enabled, cleared by an accepted
// frame, and raises expire for exactly one cycle when the count sits at
// LIMIT with no clear. A clear on that same cycle suppresses the expire.
module spi_frame_watchdog #(
  parameter logic [31:0] LIMIT = 32'd4999999
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expire
);

  logic [31:0] cnt;
  logic        fired;

  assign expire = en && !clr && (cnt == LIMIT) && !fired;

  // Counter saturates at LIMIT; fired keeps expire a single pulse until the next clear
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      fired <= 1'b0;
    end else if (clr) begin
      cnt   <= '0;
      fired <= 1'b0;
    end else if (en) begin
      if (cnt != LIMIT) cnt <= cnt + 32'd1;
      if (expire)       fired <= 1'b1;
    end
  end

endmodule

// File: rtl/spi_frame_handler.sv
// SPI frame handler: accepts frames from the SPI slave stage, supervises the
// link with a watchdog, zeroes the payload on timeout and requires a run of
// good frames before re-arming. Builds the TX frame offered back upstream.
// Optional sequence-number checking is enabled by defining SPI_FRAME_SEQ_CHECK_EN.
//
//   state   | meaning
//   IDLE    | after reset, waiting for the first frame; watchdog halted
//   RUN     | link healthy, payload exposed, rx_valid high
//   TIMEOUT | link lost, payload forced to zero, counting good frames to recover
module spi_frame_handler #(
  parameter int          BUFFER_SIZE_RX = 64,
  parameter int          BUFFER_SIZE_TX = 64,
  parameter logic [31:0] MSGID          = 32'h74697277,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd5000000,
  parameter logic [3:0]  RECOVER_FRAMES = 4'd3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [BUFFER_SIZE_RX-1:0] rx_frame,
  input  logic                      sync,
  input  logic [BUFFER_SIZE_TX-49:0] tx_payload,
  output logic [BUFFER_SIZE_TX-1:0] tx_frame,
  output logic [BUFFER_SIZE_RX-33:0] rx_payload,
  output logic                      rx_valid,
  output logic                      frame_strobe,
  output logic                      timeout_flag
);
  import spi_frame_pkg::*;

  state_t           state_q, state_d;
  logic             accept, seq_reject;
  logic             wd_expire, enter_timeout;
  logic [3:0]       good_cnt;
  logic [ERR_W-1:0] err_cnt;
  logic             seq_err_sticky;
  logic             tx_upd;

  // The message ID was matched upstream; only the payload bits matter here
  logic unused_id;
  assign unused_id = ^rx_frame[BUFFER_SIZE_RX-1:BUFFER_SIZE_RX-ID_W];

`ifdef SPI_FRAME_SEQ_CHECK_EN
  logic [SEQ_W-1:0] rx_seq, last_seq;
  logic             have_seq, seq_ok;

  assign rx_seq = rx_frame[BUFFER_SIZE_RX-33 -: SEQ_W];

  // First sync after reset/TIMEOUT entry only establishes the sequence
  always_comb begin
    seq_ok     = !have_seq || (rx_seq == last_seq + 8'd1);
    accept     = sync && seq_ok;
    seq_reject = sync && !seq_ok;
  end

  // Sequence tracking, error counter and sticky error; last_seq follows every sync to resync
  always_ff @(posedge clk) begin
    if (rst) begin
      have_seq       <= 1'b0;
      last_seq       <= '0;
      err_cnt        <= '0;
      seq_err_sticky <= 1'b0;
    end else begin
      if (enter_timeout) have_seq <= 1'b0;
      else if (sync)     have_seq <= 1'b1;
      if (sync) last_seq <= rx_seq;
      if (seq_reject) begin
        seq_err_sticky <= 1'b1;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
    end
  end
`else
  assign accept         = sync;
  assign seq_reject     = 1'b0;
  assign err_cnt        = '0;
  assign seq_err_sticky = 1'b0;
`endif

  spi_frame_watchdog #(
    .LIMIT (TIMEOUT_CYCLES - 32'd1)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .en     (state_q != IDLE),
    .clr    (accept),
    .expire (wd_expire)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; an accepted frame always beats the watchdog since expire excludes clear
  always_comb begin
    state_d       = state_q;
    enter_timeout = 1'b0;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN: begin
        if (wd_expire) begin
          state_d       = TIMEOUT;
          enter_timeout = 1'b1;
        end
      end
      TIMEOUT: if (accept && ((good_cnt + 4'd1) == RECOVER_FRAMES)) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Payload, flags, recovery count and TX frame (rebuilt the cycle after an accept or state change)
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_payload   <= '0;
      rx_valid     <= 1'b0;
      frame_strobe <= 1'b0;
      timeout_flag <= 1'b0;
      good_cnt     <= '0;
      tx_upd       <= 1'b0;
      tx_frame     <= {MSGID, {(BUFFER_SIZE_TX-ID_W){1'b0}}};
    end else begin
      frame_strobe <= accept;
      rx_valid     <= (state_d == RUN);
      tx_upd       <= accept || (state_d != state_q);

      if (state_d != RUN) rx_payload <= '0;
      else if (accept)    rx_payload <= rx_frame[BUFFER_SIZE_RX-33:0];

      if (enter_timeout) begin
        timeout_flag <= 1'b1;
        good_cnt     <= '0;
      end else if (state_q == TIMEOUT) begin
        if (wd_expire || seq_reject) good_cnt <= '0;
        else if (accept)             good_cnt <= good_cnt + 4'd1;
      end

      if (tx_upd)
        tx_frame <= {build_tx_header(MSGID, state_q, timeout_flag, seq_err_sticky,
                                     good_cnt, err_cnt), tx_payload};
    end
  end

endmodule

// File: tb/tb_spi_frame_handler.sv
// Directed bench for spi_frame_handler with a 100-cycle watchdog and 3-frame recovery.
module tb_spi_frame_handler;

  localparam logic [31:0] ID = 32'h74697277;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] rx_frame;
  logic        sync;
  logic [15:0] tx_payload;
  logic [63:0] tx_frame;
  logic [31:0] rx_payload;
  logic        rx_valid, frame_strobe, timeout_flag;

  int n_cmp = 0;
  int n_bad = 0;

  spi_frame_handler #(
    .BUFFER_SIZE_RX (64),
    .BUFFER_SIZE_TX (64),
    .MSGID          (ID),
    .TIMEOUT_CYCLES (32'd100),
    .RECOVER_FRAMES (4'd3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_frame     (rx_frame),
    .sync         (sync),
    .tx_payload   (tx_payload),
    .tx_frame     (tx_frame),
    .rx_payload   (rx_payload),
    .rx_valid     (rx_valid),
    .frame_strobe (frame_strobe),
    .timeout_flag (timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] pay);
    rx_frame = {ID, pay};
    sync     = 1'b1;
    @(posedge clk);
    #1;
    sync     = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    sync       = 1'b0;
    rx_frame   = '0;
    tx_payload = 16'h0000;

    // reset held 3 cycles
    tick(3);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_strobe", frame_strobe, 0);
    check("rst_tflag", timeout_flag, 0);
    check("rst_payload", rx_payload, 0);
    check("rst_tx_frame", tx_frame, {ID, 32'h0});
    rst = 1'b0;

    // long idle, tx_payload changes must not leak into tx_frame
    tx_payload = 16'hBEEF;
    tick(10000);
    check("idle_rx_valid", rx_valid, 0);
    check("idle_tflag", timeout_flag, 0);
    check("idle_tx_frame", tx_frame, {ID, 32'h0});

    // first frame -> RUN
    send(32'h12345678);
    check("f1_payload", rx_payload, 32'h12345678);
    check("f1_strobe", frame_strobe, 1);
    check("f1_rx_valid", rx_valid, 1);
    tick(1);
    check("f1_strobe_drop", frame_strobe, 0);
    check("f1_tx_frame", tx_frame, {ID, 8'h40, 8'h00, 16'hBEEF});
    tx_payload = 16'h1111;
    tick(5);
    check("tx_hold", tx_frame, {ID, 8'h40, 8'h00, 16'hBEEF});

    // sync on the very cycle the watchdog hits its limit wins
    send(32'h13000013);
    tick(99);
    send(32'h14AA0001);
    check("wd_edge_valid", rx_valid, 1);
    check("wd_edge_tflag", timeout_flag, 0);
    check("wd_edge_payload", rx_payload, 32'h14AA0001);

    // sync one cycle earlier also keeps RUN
    tick(98);
    send(32'h15000015);
    check("wd_99_valid", rx_valid, 1);

    // full timeout
    tx_payload = 16'h2222;
    tick(99);
    check("pre_to_valid", rx_valid, 1);
    tick(1);
    check("to_valid", rx_valid, 0);
    check("to_payload", rx_payload, 0);
    check("to_tflag", timeout_flag, 1);
    tick(1);
    check("to_tx_frame", tx_frame, {ID, 8'hA0, 8'h00, 16'h2222});

    // recovery interrupted by a watchdog expiry
    send(32'h40000040);
    check("tmo_strobe", frame_strobe, 1);
    check("tmo_payload_hidden", rx_payload, 0);
    tick(49);
    send(32'h41000041);
    tick(100);
    send(32'h42000042);
    tick(49);
    send(32'h43000043);
    check("rec_fail_valid", rx_valid, 0);
    tick(1);
    check("rec_fail_status", tx_frame[31:24], 8'hA2);

    // clean recovery: expire first, then 3 frames 50 cycles apart
    tick(110);
    tx_payload = 16'h3333;
    send(32'h44000044);
    tick(49);
    send(32'h45000045);
    check("rec_2_valid", rx_valid, 0);
    tick(49);
    send(32'h46C0FFEE);
    check("rec_valid", rx_valid, 1);
    check("rec_payload", rx_payload, 32'h46C0FFEE);
    check("rec_strobe", frame_strobe, 1);
    check("rec_tflag", timeout_flag, 1);
    tick(1);
    check("rec_tx_frame", tx_frame, {ID, 8'h63, 8'h00, 16'h3333});

    // reset coincident with sync: reset wins, frame dropped
    tx_payload = 16'h4444;
    rx_frame   = {ID, 32'h47DEAD47};
    sync       = 1'b1;
    rst        = 1'b1;
    tick(1);
    rst  = 1'b0;
    sync = 1'b0;
    check("mrst_valid", rx_valid, 0);
    check("mrst_payload", rx_payload, 0);
    check("mrst_strobe", frame_strobe, 0);
    check("mrst_tflag", timeout_flag, 0);
    check("mrst_tx_frame", tx_frame, {ID, 32'h0});
    tick(1);
    check("mrst_no_accept", frame_strobe, 0);
    check("mrst_still_idle", rx_valid, 0);

    // sequence wrap FE, FF, 00, then a gap to 05, then 06
    send(32'hFE000001);
    send(32'hFF000002);
    send(32'h00ABCDEF);
    check("seq_wrap_payload", rx_payload, 32'h00ABCDEF);
    check("seq_wrap_valid", rx_valid, 1);
    send(32'h05000005);
`ifdef SPI_FRAME_SEQ_CHECK_EN
    check("seq_bad_strobe", frame_strobe, 0);
    check("seq_bad_payload", rx_payload, 32'h00ABCDEF);
`else
    check("seq_bad_strobe", frame_strobe, 1);
    check("seq_bad_payload", rx_payload, 32'h05000005);
`endif
    send(32'h06000006);
    check("seq_next_payload", rx_payload, 32'h06000006);
    check("seq_next_strobe", frame_strobe, 1);
    tick(1);
`ifdef SPI_FRAME_SEQ_CHECK_EN
    check("seq_status_err", tx_frame[31:16], 16'h5001);
`else
    check("seq_status_err", tx_frame[31:16], 16'h4000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
